double_to_fixed_pipe: RTL and testbench
=======================================

Name: double_to_fixed_pipe

Overview:
- Pipelined converter from IEEE-754 binary64 to a parametrised fixed-point word with valid/ready handshake, selectable rounding and output format (sign-magnitude or two's complement).
- Status flags for saturation, NaN and inexact results.
- Next-generation replacement for the fixed 16-bit sign-magnitude converter.
- Sits between the double-precision filter datapath and the sample-output/DAC path; one channel per instance.

Parameters:
OUT_W, 16, total output width in bits, including sign (range 4..32).
FRAC_W, 0, fractional bits in output (0..OUT_W-2).
SIGN_MAG, 1, 1 = sign-magnitude output; 0 = two's complement.
ROUND, 1, 1 = round half away from zero; 0 = truncate toward zero.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input word valid.
in_ready  out  1  converter can accept a word this cycle.
in_double  in  64  binary64 operand.
out_valid  out  1  out_data and flags valid.
out_ready  in  1  downstream accepts the output this cycle.
out_data  out  OUT_W  converted fixed-point value.
out_ovf  out  1  result saturated: |x| too large, or ±Inf.
out_nan  out  1  input was NaN.
out_inexact  out  1  nonzero bits were discarded by rounding/truncation.

Behaviour:
- Reset: all stage valids = 0, out_valid = 0, out_data = 0, all flags = 0. Reset asserted mid-operation discards every in-flight word. in_ready = 1 in the first cycle after reset deasserts.
- Pipeline: 3 register stages; latency 3 cycles from the in_valid&in_ready accept edge to out_valid; throughput 1 word/cycle.
  - S1: unpack and classify.
  - S2: shift, guard/sticky, round.
  - S3: saturate, format, flags.
- Stall: stall = out_valid & ~out_ready. While stall is asserted, all stages hold and in_ready = 0; otherwise in_ready = 1. Bubbles are not collapsed. out_data and flags remain stable while stalled.
- Unpack:
  - s = bit63, e = bits62:52, f = bits51:0.
  - m = {(e!=0), f}, 53 bits; subnormals use hidden bit 0.
  - Shift amount sh = e − 1075 + FRAC_W, signed 13-bit.
- Magnitude:
  - sh ≥ 0: mag = m << sh. Any sh with m<<sh ≥ 2^OUT_W forces overflow; the shifter does not need to be wider than OUT_W+1 plus an overflow-detect bit.
  - sh < 0: mag = m >> −sh, with guard = bit shifted out at position −sh−1 and sticky = OR of lower bits.
  - −sh > 54: mag = 0, guard = 0, sticky = (m≠0).
- Rounding:
  - ROUND=1: mag += guard.
  - ROUND=0: no increment.
  - inexact = guard | sticky.
- Limits:
  - Positive results, both formats: max = 2^(OUT_W−1) − 1.
  - Negative results, sign-magnitude: max = 2^(OUT_W−1) − 1.
  - Negative results, two's complement: max = 2^(OUT_W−1).
  - mag > limit after rounding → mag = limit, ovf = 1, inexact = 0.
- Specials:
  - e = 2047, f = 0 (±Inf): saturate to the signed limit, ovf = 1.
  - e = 2047, f ≠ 0 (NaN): out_data = 0, nan = 1, ovf = 0, inexact = 0.
- Format:
  - Sign-magnitude: {s, mag[OUT_W−2:0]}. If mag = 0, the sign bit is forced to 0, so −0.0 and tiny negatives give all-zeros.
  - Two's complement: s ? −mag : mag, truncated to OUT_W bits.
- Flags are registered with out_data and are valid only while out_valid = 1.

Test Plan:
1. Defaults; stream 1.0, 12.5, −12.5, 0.4 with out_ready = 1 → after 3 cycles, 4 consecutive outputs 0x0001, 0x000D (inexact), 0x800D (inexact), 0x0000 (inexact, sign 0).
2. Defaults; inputs 1.0e6, −Inf, NaN → 0x7FFF ovf; 0xFFFF ovf; 0x0000 nan.
3. SIGN_MAG=0; inputs −32768.0, −32769.0, −12.5, −0.0 → 0x8000 no ovf; 0x8000 ovf; 0xFFF3 inexact; 0x0000.
4. FRAC_W=8, ROUND=1 vs ROUND=0; input 0.3 (x·256 = 76.8) → 0x004D vs 0x004C, inexact in both; input 127.99609375 → 0x7FFF exact.
5. Back-pressure: stream 5 values, hold out_ready = 0 for 4 cycles after the first out_valid → in_ready = 0 during the stall, out_data stable, no loss or duplication; order preserved after release.
6. Assert rst for 1 cycle with 3 words in flight → out_valid = 0 and out_data = 0 the next cycle; no stale word emerges afterward; new input converts with 3-cycle latency.

Source files
------------

// File: rtl/double_to_fixed_pipe.sv
// double_to_fixed_pipe
//   Three-stage pipelined converter from an IEEE-754 binary64 operand to an
//   OUT_W-bit fixed-point word with FRAC_W fractional bits. Output is either
//   sign-magnitude or two's complement. Rounding is either half away from
//   zero or truncation toward zero. Saturation, NaN and inexact results are
//   reported as flags registered alongside the data word.
//
//   Ports
//     clk          rising-edge clock
//     rst          synchronous active-high reset; drops every in-flight word
//     in_valid     input word present
//     in_ready     converter accepts a word this cycle (low only while stalled)
//     in_double    binary64 operand
//     out_valid    out_data / flags valid
//     out_ready    downstream takes the output this cycle
//     out_data     fixed-point result
//     out_ovf      saturated (|x| too large or +/-Inf)
//     out_nan      operand was NaN (out_data = 0)
//     out_inexact  nonzero bits were discarded by rounding/truncation
//
//   Stages: S1 unpack/classify, S2 shift/guard/sticky/round,
//           S3 saturate/format/flags.
module double_to_fixed_pipe #(
  parameter int OUT_W    = 16,
  parameter int FRAC_W   = 0,
  parameter int SIGN_MAG = 1,
  parameter int ROUND    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_double,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_ovf,
  output logic             out_nan,
  output logic             out_inexact
);

  localparam int STAGES = 3;
  // Left-shift workspace: 53-bit mantissa shifted by up to OUT_W, plus
  // headroom so any overflow lands in bits above OUT_W.
  localparam int SW = OUT_W + 54;
  localparam bit SM     = (SIGN_MAG != 0);
  localparam bit RND_EN = (ROUND != 0);
  localparam logic signed [12:0] SH_OFS = 13'(FRAC_W - 1075);
  localparam logic signed [12:0] SH_BIG = 13'(OUT_W);
  localparam logic [OUT_W+1:0] LIM_POS = {3'b000, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W+1:0] LIM_NEG = {2'b00, 1'b1, {(OUT_W-1){1'b0}}};

  logic [STAGES:1] vld_pipe;
  logic            stall;

  assign out_valid = vld_pipe[STAGES];
  assign stall     = vld_pipe[STAGES] & ~out_ready;
  assign in_ready  = ~stall;

  // ---------------------------------------------------------------- S1
  logic [10:0] e_in;
  logic [51:0] f_in;
  assign e_in = in_double[62:52];
  assign f_in = in_double[51:0];

  logic               s1_s, s1_inf, s1_nan;
  logic [52:0]        s1_m;
  logic signed [12:0] s1_sh;

  // ---------------------------------------------------------------- S2 comb
  logic [SW-1:0]    lwide;
  logic [107:0]     rwide;
  logic [12:0]      nsh;
  logic [5:0]       nclamp;
  logic [OUT_W:0]   mag;
  logic             big, guard, sticky;
  logic [OUT_W+1:0] mag_rnd;

  always_comb begin
    lwide  = '0;
    rwide  = '0;
    nsh    = '0;
    nclamp = '0;
    mag    = '0;
    big    = 1'b0;
    guard  = 1'b0;
    sticky = 1'b0;
    if (!s1_sh[12]) begin
      // Any shift past OUT_W overflows outright; otherwise 6 bits of shift
      // are enough and overflow shows up above bit OUT_W.
      lwide = {{(SW-53){1'b0}}, s1_m} << s1_sh[5:0];
      big   = (s1_sh > SH_BIG) | (|lwide[SW-1:OUT_W+1]);
      mag   = lwide[OUT_W:0];
    end else begin
      // Mantissa parked at the top of a 108-bit window; the 55 bits below
      // it catch guard (bit 54) and sticky (53:0). Shifts beyond 55 give
      // the same result as 55: mag=0, guard=0, sticky=(m!=0).
      nsh    = -s1_sh;
      nclamp = (nsh > 13'd55) ? 6'd55 : nsh[5:0];
      rwide  = {s1_m, 55'b0} >> nclamp;
      big    = |rwide[107:56+OUT_W];
      mag    = rwide[55+OUT_W:55];
      guard  = rwide[54];
      sticky = |rwide[53:0];
    end
    mag_rnd = {1'b0, mag} + {{(OUT_W+1){1'b0}}, guard & RND_EN};
  end

  logic             s2_s, s2_inf, s2_nan, s2_big, s2_inx;
  logic [OUT_W+1:0] s2_mag;

  // ---------------------------------------------------------------- S3 comb
  logic [OUT_W+1:0] lim;
  logic             ovf;
  logic [OUT_W-1:0] magf, data_n;

  always_comb begin
    lim  = (s2_s && !SM) ? LIM_NEG : LIM_POS;
    ovf  = s2_inf | s2_big | (s2_mag > lim);
    magf = ovf ? lim[OUT_W-1:0] : s2_mag[OUT_W-1:0];
    if (SM) begin
      // Sign is dropped on a zero magnitude so -0.0 and tiny negatives
      // come out as all zeros.
      data_n = {s2_s & (|magf), magf[OUT_W-2:0]};
    end else begin
      data_n = s2_s ? -magf : magf;
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      s1_s        <= 1'b0;
      s1_inf      <= 1'b0;
      s1_nan      <= 1'b0;
      s1_m        <= '0;
      s1_sh       <= '0;
      s2_s        <= 1'b0;
      s2_inf      <= 1'b0;
      s2_nan      <= 1'b0;
      s2_big      <= 1'b0;
      s2_inx      <= 1'b0;
      s2_mag      <= '0;
      out_data    <= '0;
      out_ovf     <= 1'b0;
      out_nan     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (!stall) begin
      vld_pipe    <= {vld_pipe[STAGES-1:1], in_valid};
      // S1
      s1_s        <= in_double[63];
      s1_inf      <= (e_in == 11'h7FF) && (f_in == '0);
      s1_nan      <= (e_in == 11'h7FF) && (f_in != '0);
      s1_m        <= {(e_in != '0), f_in};
      s1_sh       <= $signed({2'b00, e_in}) + SH_OFS;
      // S2
      s2_s        <= s1_s;
      s2_inf      <= s1_inf;
      s2_nan      <= s1_nan;
      s2_big      <= big;
      s2_inx      <= guard | sticky;
      s2_mag      <= mag_rnd;
      // S3
      out_data    <= s2_nan ? '0 : data_n;
      out_ovf     <= ovf & ~s2_nan;
      out_nan     <= s2_nan;
      out_inexact <= s2_inx & ~ovf & ~s2_nan;
    end
  end

endmodule

// File: tb/tb_double_to_fixed_pipe.sv
// Directed bench for double_to_fixed_pipe. Four instances share the input
// stream and out_ready: defaults, two's complement, and FRAC_W=8 with
// rounding on and off.
module tb_double_to_fixed_pipe;

  logic        clk, rst, in_valid, out_ready;
  logic [63:0] in_double;

  logic        rdy_def, rdy_2c, rdy_r1, rdy_r0;
  logic        dv, tv, r1v, r0v;
  logic [15:0] dd, td, r1d, r0d;
  logic        do_, dn, dx, to, tn, tx, r1o, r1n, r1x, r0o, r0n, r0x;

  double_to_fixed_pipe u_def (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_def),
    .in_double(in_double), .out_valid(dv), .out_ready(out_ready),
    .out_data(dd), .out_ovf(do_), .out_nan(dn), .out_inexact(dx));

  double_to_fixed_pipe #(.SIGN_MAG(0)) u_2c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_2c),
    .in_double(in_double), .out_valid(tv), .out_ready(out_ready),
    .out_data(td), .out_ovf(to), .out_nan(tn), .out_inexact(tx));

  double_to_fixed_pipe #(.FRAC_W(8), .ROUND(1)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r1),
    .in_double(in_double), .out_valid(r1v), .out_ready(out_ready),
    .out_data(r1d), .out_ovf(r1o), .out_nan(r1n), .out_inexact(r1x));

  double_to_fixed_pipe #(.FRAC_W(8), .ROUND(0)) u_r0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_r0),
    .in_double(in_double), .out_valid(r0v), .out_ready(out_ready),
    .out_data(r0d), .out_ovf(r0o), .out_nan(r0n), .out_inexact(r0x));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // {valid, ovf, nan, inexact, data}
  function automatic logic [63:0] pk(input logic v, input logic [15:0] d,
                                     input logic o, input logic nn, input logic x);
    return {44'b0, v, o, nn, x, d};
  endfunction

  localparam int M_DEF = 1, M_2C = 2, M_R1 = 4, M_R0 = 8;

  logic [63:0] st[8];
  logic [63:0] e_def[8], e_2c[8], e_r1[8], e_r0[8];

  // Stream n words back to back with out_ready=1; word j must appear on
  // the third negedge after it is driven, consecutively.
  task automatic run_stream(input string name, input int n, input int mask);
    for (int i = 0; i < n + 2; i++) begin
      in_valid  = (i < n);
      in_double = (i < n) ? st[i] : 64'h0;
      @(negedge clk);
      if (i < 2) begin
        chk($sformatf("%s_lat%0d", name, i), {63'b0, dv}, 64'h0);
      end else begin
        if ((mask & M_DEF) != 0) chk($sformatf("%s_def%0d", name, i-2), pk(dv, dd, do_, dn, dx), e_def[i-2]);
        if ((mask & M_2C)  != 0) chk($sformatf("%s_2c%0d",  name, i-2), pk(tv, td, to, tn, tx), e_2c[i-2]);
        if ((mask & M_R1)  != 0) chk($sformatf("%s_r1_%0d", name, i-2), pk(r1v, r1d, r1o, r1n, r1x), e_r1[i-2]);
        if ((mask & M_R0)  != 0) chk($sformatf("%s_r0_%0d", name, i-2), pk(r0v, r0d, r0o, r0n, r0x), e_r0[i-2]);
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_tail", name), {63'b0, dv}, 64'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, got, stall_left, extra, stale;
    logic seen;
    logic [15:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_double = 64'h0;
    repeat (3) @(negedge clk);
    chk("rst_def", pk(dv, dd, do_, dn, dx), 64'h0);
    chk("rst_2c",  pk(tv, td, to, tn, tx), 64'h0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", {63'b0, rdy_def}, 64'h1);
    @(negedge clk);

    // 1: basic stream
    st[0] = 64'h3FF0000000000000;  // 1.0
    st[1] = 64'h4029000000000000;  // 12.5
    st[2] = 64'hC029000000000000;  // -12.5
    st[3] = 64'h3FD999999999999A;  // 0.4
    e_def[0] = pk(1, 16'h0001, 0, 0, 0); e_2c[0] = pk(1, 16'h0001, 0, 0, 0);
    e_def[1] = pk(1, 16'h000D, 0, 0, 1); e_2c[1] = pk(1, 16'h000D, 0, 0, 1);
    e_def[2] = pk(1, 16'h800D, 0, 0, 1); e_2c[2] = pk(1, 16'hFFF3, 0, 0, 1);
    e_def[3] = pk(1, 16'h0000, 0, 0, 1); e_2c[3] = pk(1, 16'h0000, 0, 0, 1);
    run_stream("basic", 4, M_DEF | M_2C);

    // 2: overflow / specials
    st[0] = 64'h412E848000000000;  // 1.0e6
    st[1] = 64'hFFF0000000000000;  // -Inf
    st[2] = 64'h7FF8000000000000;  // NaN
    e_def[0] = pk(1, 16'h7FFF, 1, 0, 0); e_2c[0] = pk(1, 16'h7FFF, 1, 0, 0);
    e_def[1] = pk(1, 16'hFFFF, 1, 0, 0); e_2c[1] = pk(1, 16'h8000, 1, 0, 0);
    e_def[2] = pk(1, 16'h0000, 0, 1, 0); e_2c[2] = pk(1, 16'h0000, 0, 1, 0);
    run_stream("spec", 3, M_DEF | M_2C);

    // 3: negative limits
    st[0] = 64'hC0E0000000000000;  // -32768.0
    st[1] = 64'hC0E0002000000000;  // -32769.0
    st[2] = 64'hC029000000000000;  // -12.5
    st[3] = 64'h8000000000000000;  // -0.0
    e_2c[0] = pk(1, 16'h8000, 0, 0, 0); e_def[0] = pk(1, 16'hFFFF, 1, 0, 0);
    e_2c[1] = pk(1, 16'h8000, 1, 0, 0); e_def[1] = pk(1, 16'hFFFF, 1, 0, 0);
    e_2c[2] = pk(1, 16'hFFF3, 0, 0, 1); e_def[2] = pk(1, 16'h800D, 0, 0, 1);
    e_2c[3] = pk(1, 16'h0000, 0, 0, 0); e_def[3] = pk(1, 16'h0000, 0, 0, 0);
    run_stream("neg", 4, M_DEF | M_2C);

    // 4: fractional bits, round vs truncate
    st[0] = 64'h3FD3333333333333;  // 0.3
    st[1] = 64'h405FFFC000000000;  // 127.99609375
    e_r1[0] = pk(1, 16'h004D, 0, 0, 1); e_r0[0] = pk(1, 16'h004C, 0, 0, 1);
    e_r1[1] = pk(1, 16'h7FFF, 0, 0, 0); e_r0[1] = pk(1, 16'h7FFF, 0, 0, 0);
    run_stream("frac", 2, M_R1 | M_R0);

    // 5: back-pressure
    st[0] = 64'h3FF0000000000000;  // 1.0
    st[1] = 64'h4000000000000000;  // 2.0
    st[2] = 64'h4008000000000000;  // 3.0
    st[3] = 64'h4029000000000000;  // 12.5
    st[4] = 64'hC029000000000000;  // -12.5
    e_def[0] = pk(1, 16'h0001, 0, 0, 0);
    e_def[1] = pk(1, 16'h0002, 0, 0, 0);
    e_def[2] = pk(1, 16'h0003, 0, 0, 0);
    e_def[3] = pk(1, 16'h000D, 0, 0, 1);
    e_def[4] = pk(1, 16'h800D, 0, 0, 1);
    idx = 0; got = 0; stall_left = 0; seen = 1'b0; held = '0;
    for (int c = 0; c < 60 && got < 5; c++) begin
      if (dv && !seen) begin
        seen = 1'b1;
        stall_left = 4;
        held = dd;
      end
      out_ready = (stall_left == 0);
      in_valid  = (idx < 5);
      in_double = (idx < 5) ? st[idx] : 64'h0;
      #1;
      if (stall_left > 0) begin
        chk($sformatf("bp_rdy%0d", stall_left), {63'b0, rdy_def}, 64'h0);
        chk($sformatf("bp_hold%0d", stall_left), {48'b0, dd}, {48'b0, held});
        stall_left--;
      end
      if (in_valid && rdy_def) idx++;
      if (dv && out_ready) begin
        chk($sformatf("bp_out%0d", got), pk(dv, dd, do_, dn, dx), e_def[got]);
        got++;
      end
      @(negedge clk);
    end
    chk("bp_count", 64'(got), 64'd5);
    in_valid = 1'b0; out_ready = 1'b1;
    extra = 0;
    repeat (5) begin
      #1;
      if (dv) extra++;
      @(negedge clk);
    end
    chk("bp_extra", 64'(extra), 64'd0);

    // 6: reset with words in flight
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_double = st[k];
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_vld", {63'b0, dv}, 64'h0);
    chk("mid_rst_data", {48'b0, dd}, 64'h0);
    rst = 1'b0;
    #1;
    chk("mid_rst_rdy", {63'b0, rdy_def}, 64'h1);
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (dv) stale++;
    end
    chk("mid_rst_stale", 64'(stale), 64'd0);
    st[0] = 64'h4008000000000000;  // 3.0
    e_def[0] = pk(1, 16'h0003, 0, 0, 0);
    run_stream("post_rst", 1, M_DEF);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
